// File: rtl/label_fetch_sequencer.sv
// Per-scanline label overlay sequencer: detects label bands, fetches 4 glyph rows through the
// character map and glyph ROM, and shifts the resulting 24-pixel row out on pix_tick.
module label_fetch_sequencer (
    input  logic       CK,
    input  logic       RST,
    input  logic       hs_start,
    input  logic [8:0] ypix,
    input  logic       pix_tick,
    output logic       map_en,
    output logic [3:0] map_ychr,
    output logic [2:0] map_xchr,
    input  logic [3:0] map_chr,
    output logic       rom_en,
    output logic [3:0] rom_chr,
    output logic [2:0] rom_scany,
    input  logic [5:0] rom_out,
    output logic       pix_on,
    output logic       busy,
    output logic       late
);

    localparam logic [4:0] LineCols = 5'd24;

    typedef enum logic [2:0] {
        StIdle,
        StMap,
        StLatch,
        StRom,
        StStore,
        StReady
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  xi_q;
    logic [4:0]  xcnt_q;
    logic [5:0]  glyph_buf [4];
    logic [23:0] glyph_row;
    logic [4:0]  col_idx;

    logic        band_hit;
    logic [3:0]  band_k;
    logic [2:0]  band_row;
    logic [9:0]  band_diff;

    // Bands 0..10 are on a 40-line pitch; the last one is pulled up to fit the 480-line screen.
    function automatic logic [9:0] band_start(input int k);
        if (k == 11) begin
            return 10'd472;
        end
        return 10'(36 + 40 * k);
    endfunction

    // Lines above a band start wrap to large differences, so one unsigned compare suffices.
    always_comb begin
        band_hit  = 1'b0;
        band_k    = '0;
        band_row  = '0;
        band_diff = '0;
        for (int k = 0; k < 12; k++) begin
            band_diff = {1'b0, ypix} - band_start(k);
            if (band_diff < 10'd8) begin
                band_hit = 1'b1;
                band_k   = 4'(k);
                band_row = band_diff[2:0];
            end
        end
    end

    // Character 0 occupies the leftmost (most significant) six pixels.
    assign glyph_row = {glyph_buf[0], glyph_buf[1], glyph_buf[2], glyph_buf[3]};
    assign col_idx   = 5'd23 - xcnt_q;

    assign busy     = (state_q == StMap) || (state_q == StLatch) ||
                      (state_q == StRom) || (state_q == StStore);
    assign map_xchr = {1'b0, xi_q};

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (hs_start) begin
            state_d = band_hit ? StMap : StIdle;
        end else begin
            case (state_q)
                StIdle:  state_d = StIdle;
                StMap:   state_d = StLatch;
                StLatch: state_d = StRom;
                StRom:   state_d = StStore;
                StStore: state_d = (xi_q == 2'd3) ? StReady : StMap;
                StReady: state_d = (xcnt_q == LineCols) ? StIdle : StReady;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            map_en    <= 1'b0;
            rom_en    <= 1'b0;
            map_ychr  <= '0;
            rom_chr   <= '0;
            rom_scany <= '0;
            xi_q      <= '0;
            xcnt_q    <= LineCols;
            pix_on    <= 1'b0;
            late      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                glyph_buf[i] <= '0;
            end
        end else begin
            // Strobes come from the next state so they line up with the state they belong to.
            map_en <= (state_d == StMap);
            rom_en <= (state_d == StRom);
            if (hs_start) begin
                map_ychr  <= band_k;
                rom_scany <= band_row;
                xi_q      <= '0;
                xcnt_q    <= '0;
                pix_on    <= 1'b0;
            end else begin
                if (state_q == StLatch) begin
                    rom_chr <= map_chr;
                end
                if (state_q == StStore) begin
                    glyph_buf[xi_q] <= rom_out;
                    if (xi_q != 2'd3) begin
                        xi_q <= xi_q + 2'd1;
                    end
                end
                if (pix_tick) begin
                    if (xcnt_q < LineCols) begin
                        xcnt_q <= xcnt_q + 5'd1;
                        pix_on <= (state_q == StReady) ? glyph_row[col_idx] : 1'b0;
                        if (busy) begin
                            late <= 1'b1;
                        end
                    end else begin
                        pix_on <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_label_fetch_sequencer.sv
// Scoreboard bench for label_fetch_sequencer: stimulus queues expected strobes and pixels,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_label_fetch_sequencer;

    logic       CK = 1'b0;
    logic       RST = 1'b0;
    logic       hs_start = 1'b0;
    logic [8:0] ypix = '0;
    logic       pix_tick = 1'b0;
    logic [3:0] map_chr = '0;
    logic [5:0] rom_out = '0;
    logic       map_en, rom_en, pix_on, busy, late;
    logic [3:0] map_ychr, rom_chr;
    logic [2:0] map_xchr, rom_scany;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [3:0] a;
        logic [2:0] b;
    } exp_t;

    exp_t map_q[$];
    exp_t rom_q[$];
    logic pix_q[$];
    logic pend = 1'b0;

    logic [3:0] map_tab [16][4];
    logic [5:0] rom_rows [16];

    label_fetch_sequencer dut (
        .CK        (CK),
        .RST       (RST),
        .hs_start  (hs_start),
        .ypix      (ypix),
        .pix_tick  (pix_tick),
        .map_en    (map_en),
        .map_ychr  (map_ychr),
        .map_xchr  (map_xchr),
        .map_chr   (map_chr),
        .rom_en    (rom_en),
        .rom_chr   (rom_chr),
        .rom_scany (rom_scany),
        .rom_out   (rom_out),
        .pix_on    (pix_on),
        .busy      (busy),
        .late      (late)
    );

    always #5 CK = ~CK;

    always @(posedge CK) cyc <= cyc + 1;

    // Registered-read stubs for the character map and glyph ROM.
    always @(posedge CK) begin
        if (map_en) map_chr <= map_tab[map_ychr][map_xchr[1:0]];
        if (rom_en) rom_out <= rom_rows[rom_chr];
    end

    always @(negedge CK) begin : monitor
        exp_t e;
        logic pe;
        if (RST) begin
            pend = 1'b0;
        end else begin
            if (map_en || rom_en) begin
                checks++;
                if (map_en && rom_en) begin
                    errors++;
                    $display("FAIL strobe_overlap: map_en=1 rom_en=1, required not both (cycle %0d)",
                             cyc);
                end
            end
            if (map_en) begin
                checks++;
                if (map_q.size() == 0) begin
                    errors++;
                    $display("FAIL map_unexpected: map_en=1 ychr=%0d xchr=%0d, required none (cycle %0d)",
                             map_ychr, map_xchr, cyc);
                end else begin
                    e = map_q.pop_front();
                    if (e.cyc != cyc || e.a !== map_ychr || e.b !== map_xchr) begin
                        errors++;
                        $display("FAIL map_fetch: got cycle %0d ychr %0d xchr %0d, required cycle %0d ychr %0d xchr %0d",
                                 cyc, map_ychr, map_xchr, e.cyc, e.a, e.b);
                    end
                end
            end
            if (rom_en) begin
                checks++;
                if (rom_q.size() == 0) begin
                    errors++;
                    $display("FAIL rom_unexpected: rom_en=1 chr=%0d scany=%0d, required none (cycle %0d)",
                             rom_chr, rom_scany, cyc);
                end else begin
                    e = rom_q.pop_front();
                    if (e.cyc != cyc || e.a !== rom_chr || e.b !== rom_scany) begin
                        errors++;
                        $display("FAIL rom_fetch: got cycle %0d chr %0d scany %0d, required cycle %0d chr %0d scany %0d",
                                 cyc, rom_chr, rom_scany, e.cyc, e.a, e.b);
                    end
                end
            end
            if (pend) begin
                checks++;
                if (pix_q.size() == 0) begin
                    errors++;
                    $display("FAIL pix_queue: pix_on=%0b with no expectation (cycle %0d)", pix_on, cyc);
                end else begin
                    pe = pix_q.pop_front();
                    if (pix_on !== pe) begin
                        errors++;
                        $display("FAIL pix_on: got %0b, required %0b (cycle %0d)", pix_on, pe, cyc);
                    end
                end
            end
            pend = pix_tick && !hs_start;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic start_line(input logic [8:0] y, output int b);
        hs_start = 1'b1;
        ypix     = y;
        b        = cyc;
        step();
        hs_start = 1'b0;
    endtask

    task automatic push_char(input int b, input int x, input logic [3:0] k, input logic [2:0] sy);
        exp_t e;
        e.cyc = b + 1 + 4 * x;
        e.a   = k;
        e.b   = 3'(x);
        map_q.push_back(e);
        e.cyc = b + 3 + 4 * x;
        e.a   = map_tab[k][x];
        e.b   = sy;
        rom_q.push_back(e);
    endtask

    task automatic push_fetch(input int b, input logic [3:0] k, input logic [2:0] sy);
        for (int x = 0; x < 4; x++) push_char(b, x, k, sy);
    endtask

    task automatic tick(input logic e);
        pix_q.push_back(e);
        pix_tick = 1'b1;
        step();
        pix_tick = 1'b0;
    endtask

    task automatic ticks_row(input logic [23:0] row, input int from, input int to);
        logic [23:0] r;
        r = row;
        for (int c = from; c <= to; c++) tick(r[23-c]);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_map_en", 32'(map_en), 32'd0);
        chk("rst_rom_en", 32'(rom_en), 32'd0);
        chk("rst_pix_on", 32'(pix_on), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_late", 32'(late), 32'd0);
        chk("rst_map_ychr", 32'(map_ychr), 32'd0);
        chk("rst_map_xchr", 32'(map_xchr), 32'd0);
        chk("rst_rom_chr", 32'(rom_chr), 32'd0);
        chk("rst_rom_scany", 32'(rom_scany), 32'd0);
    endtask

    initial begin
        int b, b2;
        logic [8:0] oob [3];

        for (int i = 0; i < 16; i++) begin
            rom_rows[i] = 6'b000000;
            for (int x = 0; x < 4; x++) map_tab[i][x] = 4'hF;
        end
        map_tab[0]  = '{4'd2, 4'd2, 4'd0, 4'd0};
        map_tab[1]  = '{4'd1, 4'd2, 4'd3, 4'd4};
        map_tab[2]  = '{4'd1, 4'd2, 4'd3, 4'd4};
        map_tab[11] = '{4'd5, 4'd6, 4'd7, 4'd8};
        rom_rows[0] = 6'b001110;
        rom_rows[1] = 6'b101100;
        rom_rows[2] = 6'b001110;
        rom_rows[3] = 6'b111000;
        rom_rows[4] = 6'b000111;
        rom_rows[5] = 6'b110101;
        rom_rows[6] = 6'b011010;
        rom_rows[7] = 6'b100110;
        rom_rows[8] = 6'b001011;

        // Power-on reset.
        #2 RST = 1'b1;
        #1 chk_reset_outputs();
        step();
        step();
        RST = 1'b0;
        // Idle ticks with xcnt saturated give dark pixels.
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);

        // First band: ypix 36 -> k 0, row 0, codes 2,2,0,0.
        start_line(9'd36, b);
        push_fetch(b, 4'd0, 3'd0);
        chk("busy_c1", 32'(busy), 32'd1);
        wait_until(b + 16);
        chk("busy_c16", 32'(busy), 32'd1);
        step();
        chk("busy_c17", 32'(busy), 32'd0);
        wait_until(b + 20);
        ticks_row(24'b001110_001110_001110_001110, 0, 23);
        tick(1'b0);
        tick(1'b0);
        chk("late_clean", 32'(late), 32'd0);

        // Last band and mid-READY reset: ypix 479 -> k 11, row 7, codes 5,6,7,8.
        step();
        start_line(9'd479, b);
        push_fetch(b, 4'd11, 3'd7);
        wait_until(b + 20);
        tick(1'b1);
        step();
        chk("pre_rst_pix_on", 32'(pix_on), 32'd1);
        chk("pre_rst_ychr", 32'(map_ychr), 32'd11);
        #2 RST = 1'b1;
        #1 chk_reset_outputs();
        step();
        RST = 1'b0;
        tick(1'b0);
        repeat (6) step();

        // Out-of-band lines stay idle and dark.
        oob = '{9'd35, 9'd44, 9'd471};
        for (int i = 0; i < 3; i++) begin
            start_line(oob[i], b);
            chk("oob_busy", 32'(busy), 32'd0);
            for (int t = 0; t < 30; t++) tick(1'b0);
            chk("oob_busy_end", 32'(busy), 32'd0);
        end

        // Late tick: ypix 118 -> k 2, row 2; tick in cycle 5 lands during MAP.
        start_line(9'd118, b);
        push_fetch(b, 4'd2, 3'd2);
        wait_until(b + 5);
        tick(1'b0);
        chk("late_set", 32'(late), 32'd1);
        wait_until(b + 18);
        ticks_row(24'b101100_001110_111000_000111, 1, 23);
        tick(1'b0);

        // Restart: second hs_start in cycle 7 with ypix 76 -> k 1, row 0.
        step();
        start_line(9'd36, b);
        push_char(b, 0, 4'd0, 3'd0);
        push_char(b, 1, 4'd0, 3'd0);
        wait_until(b + 2);
        tick(1'b0);
        tick(1'b0);
        wait_until(b + 7);
        start_line(9'd76, b2);
        push_fetch(b2, 4'd1, 3'd0);
        wait_until(b2 + 18);
        ticks_row(24'b101100_001110_111000_000111, 0, 23);
        tick(1'b0);

        repeat (5) step();
        chk("map_q_drained", 32'(map_q.size()), 32'd0);
        chk("rom_q_drained", 32'(rom_q.size()), 32'd0);
        chk("pix_q_drained", 32'(pix_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
